mmio_io: RTL and testbench
==========================

Name: mmio_io

Overview:
Memory-mapped I/O slave on the memory stage of the 3-stage RISC-V pipeline. It decodes the 0x8000_00xx address window alongside dmem and bios_mem. It exposes UART status, RX data, TX data, a cycle counter and a retired-instruction counter. RX bytes from the on-chip uart are buffered in a small FIFO so software polling does not lose characters. Read data is synchronous and has the same one-cycle latency as dmem, so it plugs into the existing writeback mux.

Parameters:
RX_DEPTH, 8, RX FIFO entries (power of 2, >=2)
BASE_ADDR, 32'h8000_0000, base of the MMIO window; decode compares addr[31:8]

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
addr  in  32  byte address from the execute-stage ALU result
wdata  in  32  store data
we  in  4  byte write enables; any nonzero bit counts as a write
re  in  1  load request
rdata  out  32  load data, valid the cycle after re
inst_retire  in  1  one pulse per instruction retired in writeback
uart_rx_data  in  8  uart data_out
uart_rx_valid  in  1  uart data_out_valid
uart_rx_ready  out  1  uart data_out_ready
uart_tx_data  out  8  uart data_in
uart_tx_valid  out  1  uart data_in_valid
uart_tx_ready  in  1  uart data_in_ready

Behaviour:
- Reset (rst=0, async): rdata=0, uart_tx_valid=0, uart_tx_data=0, FIFO empty, cycle_cnt=0, inst_cnt=0. uart_rx_ready=1 after reset because the FIFO is not full.
- Hit = addr[31:8]==BASE_ADDR[31:8]. Offsets use addr[7:0]; addr[1:0] is ignored, giving word access only.
- Register map:
  - 0x00 status (RO): bit0=tx_ready, bit1=rx_valid, others 0.
  - 0x04 rx_data (RO, pop on read).
  - 0x08 tx_data (WO).
  - 0x10 cycle_cnt (RO).
  - 0x14 inst_cnt (RO).
  - 0x18 cnt_reset (WO, any data).
- Unmapped offset or no hit: the read returns 0 and the write is ignored. A write to an RO register or a read of a WO register is ignored and returns 0.
- Read path: on a clk edge with re && hit, rdata <= the selected value. Otherwise rdata <= 0. Latency is exactly 1 cycle.
- tx_ready = !uart_tx_valid && uart_tx_ready (combinational).
- TX write with tx_ready=1: uart_tx_data <= wdata[7:0], uart_tx_valid <= 1.
  - uart_tx_valid is held until the cycle where uart_tx_valid && uart_tx_ready, then it clears on the next edge.
  - A TX write with tx_ready=0 is dropped silently; uart_tx_data is unchanged.
- RX FIFO:
  - Push when uart_rx_valid && uart_rx_ready. uart_rx_ready = !full, based on the pre-pop count.
  - rx_valid = !empty.
  - A read of 0x04 returns {24'b0, head} and pops, only if non-empty. A read of 0x04 when empty returns 0 and count is unchanged.
  - Simultaneous push and pop (non-empty, non-full): count is unchanged and data order is preserved.
  - When full, push is blocked even if a pop occurs in the same cycle.
  - Pointers are log2(RX_DEPTH) bits and wrap modulo RX_DEPTH. count is log2(RX_DEPTH)+1 bits.
- Counters: 32-bit, wrap 0xFFFF_FFFF->0.
  - cycle_cnt increments every cycle.
  - inst_cnt increments on inst_retire.
  - A write to 0x18 sets both counters to 0 on that edge and takes priority over increment. Both counters read 0 the cycle after.
  - A read of a counter returns its value before the edge.
- A simultaneous re and we to the same hit is illegal; the bench does not drive it, and the result is undefined.
- Reset asserted mid-transfer: tx_valid drops immediately, the pending TX byte is lost, and the FIFO contents are discarded.

Decomposition:
- Shared package/header mmio_defs: MMIO_BASE, offsets MMIO_STATUS/RX/TX/CYC/INST/CNT_RST, status bit indices.
- Sub-module rx_fifo (parameter DEPTH, WIDTH=8; ports push/din/full, pop/dout/empty, async active-low reset) instantiated once.
- mmio_io holds the decode, TX handshake register, counters and read mux.

Test Plan:
- Reset, then read 0x8000_0000 with uart_tx_ready=1 -> rdata=0x0000_0001 next cycle; uart_rx_ready=1.
- Write 0x41 to 0x8000_0008, uart_tx_ready=0 for 3 cycles then 1 -> uart_tx_valid high 4 cycles with data 0x41; a second write during the busy period is dropped (no second byte seen).
- Push 0x11, 0x22, 0x33 via uart_rx, then read 0x04 three times -> 0x11, 0x22, 0x33; a fourth read -> 0, status bit1=0.
- Push 8 bytes without reading -> uart_rx_ready=0; a 9th valid byte is not accepted. Read once -> ready returns to 1; a full read-out order matches the push order, including across pointer wrap.
- Pulse inst_retire 5 times over 20 cycles, read 0x14 -> 5. Write 0x18, then read 0x10 and 0x14 the next cycle -> both small (0 and 0 plus elapsed cycles for cycle_cnt only).
- Force cycle_cnt to 0xFFFF_FFFF -> it reads 0 one cycle later. Assert rst low mid-TX -> uart_tx_valid falls without waiting for clk, and the FIFO is empty afterward.

Source files
------------

// File: rtl/mmio_io_pkg.sv
// Shared definitions for the MMIO slave: window base, register offsets,
// status bit positions and the offset decoder.
package mmio_io_pkg;

    localparam logic [31:0] MMIO_BASE    = 32'h8000_0000;

    localparam logic [7:0]  MMIO_STATUS  = 8'h00;
    localparam logic [7:0]  MMIO_RX      = 8'h04;
    localparam logic [7:0]  MMIO_TX      = 8'h08;
    localparam logic [7:0]  MMIO_CYC     = 8'h10;
    localparam logic [7:0]  MMIO_INST    = 8'h14;
    localparam logic [7:0]  MMIO_CNT_RST = 8'h18;

    localparam int STATUS_TX_READY = 0;
    localparam int STATUS_RX_VALID = 1;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_STATUS,
        REG_RX,
        REG_TX,
        REG_CYC,
        REG_INST,
        REG_CNT_RST
    } reg_sel_e;

    // Word index only: byte lanes within a register are not distinguished.
    function automatic reg_sel_e decode_offset(input logic [5:0] word);
        case (word)
            MMIO_STATUS[7:2]:  return REG_STATUS;
            MMIO_RX[7:2]:      return REG_RX;
            MMIO_TX[7:2]:      return REG_TX;
            MMIO_CYC[7:2]:     return REG_CYC;
            MMIO_INST[7:2]:    return REG_INST;
            MMIO_CNT_RST[7:2]: return REG_CNT_RST;
            default:           return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mmio_io_rx_fifo.sv
// Small synchronous FIFO buffering received UART bytes until software polls.
module rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    // Full is judged on the pre-pop count, so a pop never opens room the same cycle.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; count guards every read so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_io.sv
// MMIO slave: UART status/RX/TX registers plus cycle and retired-instruction
// counters, with dmem-matching one-cycle synchronous read data.
module mmio_io
    import mmio_io_pkg::*;
#(
    parameter int          RX_DEPTH  = 8,
    parameter logic [31:0] BASE_ADDR = MMIO_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  we,
    input  logic        re,
    output logic [31:0] rdata,
    input  logic        inst_retire,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready
);

    logic        hit;
    logic        rd;
    logic        wr;
    reg_sel_e    sel;
    logic        tx_ready;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic [31:0] cycle_cnt;
    logic [31:0] inst_cnt;
    logic [31:0] rd_mux;
    logic        unused_bits;

    assign unused_bits = &{1'b0, addr[1:0], wdata[31:8]};

    assign hit      = (addr[31:8] == BASE_ADDR[31:8]);
    assign sel      = decode_offset(addr[7:2]);
    assign rd       = re && hit;
    assign wr       = (|we) && hit;
    assign tx_ready = !uart_tx_valid && uart_tx_ready;

    assign uart_rx_ready = !fifo_full;

    rx_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (uart_rx_valid),
        .din   (uart_rx_data),
        .full  (fifo_full),
        .pop   (rd && (sel == REG_RX)),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    // NOTE: every variable gets a default first so this block can never infer a latch.
    always_comb begin
        rd_mux = '0;
        case (sel)
            REG_STATUS: begin
                rd_mux[STATUS_TX_READY] = tx_ready;
                rd_mux[STATUS_RX_VALID] = !fifo_empty;
            end
            REG_RX:   rd_mux = fifo_empty ? 32'h0 : {24'h0, fifo_dout};
            REG_CYC:  rd_mux = cycle_cnt;
            REG_INST: rd_mux = inst_cnt;
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdata <= '0;
        else      rdata <= rd ? rd_mux : 32'h0;
    end

    // Accepting a write requires !uart_tx_valid, so it never overlaps the handshake clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            uart_tx_valid <= 1'b0;
            uart_tx_data  <= '0;
        end else if (uart_tx_valid && uart_tx_ready) begin
            uart_tx_valid <= 1'b0;
        end else if (wr && (sel == REG_TX) && tx_ready) begin
            uart_tx_valid <= 1'b1;
            uart_tx_data  <= wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt <= '0;
            inst_cnt  <= '0;
        end else if (wr && (sel == REG_CNT_RST)) begin
            cycle_cnt <= '0;
            inst_cnt  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            inst_cnt  <= inst_cnt + {31'h0, inst_retire};
        end
    end

endmodule

// File: tb/tb_mmio_io.sv
// Self-checking bench for mmio_io: register-map table, directed UART/counter
// sequences, and randomized traffic against a queue-based reference model.
module tb_mmio_io;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  we = '0;
    logic        re = 1'b0;
    logic [31:0] rdata;
    logic        inst_retire = 1'b0;
    logic [7:0]  uart_rx_data = '0;
    logic        uart_rx_valid = 1'b0;
    logic        uart_rx_ready;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    mmio_io #(.RX_DEPTH(8), .BASE_ADDR(32'h8000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .addr          (addr),
        .wdata         (wdata),
        .we            (we),
        .re            (re),
        .rdata         (rdata),
        .inst_retire   (inst_retire),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a; re = 1'b1; we = '0;
        step();
        d = rdata;
        re = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 4'hF; re = 1'b0;
        step();
        we = '0;
    endtask

    task automatic rx_push(input logic [7:0] b);
        uart_rx_data = b; uart_rx_valid = 1'b1;
        step();
        uart_rx_valid = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
        logic        re;
        logic [31:0] exp;
    } vec_t;

    // Reference model state for the randomized phase.
    logic [7:0]  m_q[$];
    logic        m_tx_v;
    logic [7:0]  m_tx_d;
    logic [31:0] m_cyc;
    logic [31:0] m_inst;

    initial begin
        vec_t        vecs[14];
        logic [31:0] d;
        int          high_cnt;

        // ---------------- reset ----------------
        uart_tx_ready = 1'b1;
        repeat (3) step();
        check("reset_rdata", rdata, 32'h0);
        check("reset_tx_valid", {31'h0, uart_tx_valid}, 32'h0);
        check("reset_tx_data", {24'h0, uart_tx_data}, 32'h0);
        check("reset_rx_ready", {31'h0, uart_rx_ready}, 32'h1);
        rst = 1'b1;
        step();

        bus_read(32'h8000_0000, d);
        check("status_after_reset", d, 32'h1);
        check("rx_ready_after_reset", {31'h0, uart_rx_ready}, 32'h1);

        // ---------------- register-map table ----------------
        vecs[0]  = '{32'h8000_0000, 32'h0,        4'h0, 1'b1, 32'h1};
        vecs[1]  = '{32'h8000_0003, 32'h0,        4'h0, 1'b1, 32'h1};
        vecs[2]  = '{32'h8000_0004, 32'h0,        4'h0, 1'b1, 32'h0};
        vecs[3]  = '{32'h8000_0008, 32'h0,        4'h0, 1'b1, 32'h0};
        vecs[4]  = '{32'h8000_000C, 32'h0,        4'h0, 1'b1, 32'h0};
        vecs[5]  = '{32'h8000_001C, 32'h0,        4'h0, 1'b1, 32'h0};
        vecs[6]  = '{32'h8000_0018, 32'h0,        4'h0, 1'b1, 32'h0};
        vecs[7]  = '{32'h8000_0100, 32'h0,        4'h0, 1'b1, 32'h0};
        vecs[8]  = '{32'h0000_0000, 32'h0,        4'h0, 1'b1, 32'h0};
        vecs[9]  = '{32'h8000_0000, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0};
        vecs[10] = '{32'h8000_0004, 32'h0000_0055, 4'h1, 1'b0, 32'h0};
        vecs[11] = '{32'h8000_0000, 32'h0,        4'h0, 1'b1, 32'h1};
        vecs[12] = '{32'h9000_0008, 32'h0000_0077, 4'hF, 1'b0, 32'h0};
        vecs[13] = '{32'h8000_0000, 32'h0,        4'h0, 1'b1, 32'h1};
        for (int i = 0; i < 14; i++) begin
            addr = vecs[i].addr; wdata = vecs[i].wdata;
            we = vecs[i].we; re = vecs[i].re;
            step();
            check($sformatf("table[%0d]", i), rdata, vecs[i].exp);
        end
        re = 1'b0; we = '0;
        check("table_no_tx", {31'h0, uart_tx_valid}, 32'h0);

        // ---------------- TX handshake ----------------
        uart_tx_ready = 1'b1;
        bus_write(32'h8000_0008, 32'h0000_0041);
        high_cnt = 0;
        uart_tx_ready = 1'b0;
        if (uart_tx_valid) high_cnt++;
        check("tx_data_41", {24'h0, uart_tx_data}, 32'h41);
        for (int i = 0; i < 3; i++) begin
            if (i == 0) bus_write(32'h8000_0008, 32'h0000_0099);
            else        step();
            if (i == 2) uart_tx_ready = 1'b1;
            if (uart_tx_valid) high_cnt++;
            check("tx_hold_data", {24'h0, uart_tx_data}, 32'h41);
        end
        step();
        check("tx_valid_cycles", high_cnt, 32'd4);
        check("tx_cleared", {31'h0, uart_tx_valid}, 32'h0);
        repeat (3) step();
        check("tx_no_second_byte", {31'h0, uart_tx_valid}, 32'h0);

        // ---------------- RX basic ----------------
        rx_push(8'h11); rx_push(8'h22); rx_push(8'h33);
        bus_read(32'h8000_0004, d); check("rx_read0", d, 32'h11);
        bus_read(32'h8000_0004, d); check("rx_read1", d, 32'h22);
        bus_read(32'h8000_0004, d); check("rx_read2", d, 32'h33);
        bus_read(32'h8000_0004, d); check("rx_read_empty", d, 32'h0);
        bus_read(32'h8000_0000, d); check("status_rx_empty", d & 32'h2, 32'h0);

        // ---------------- RX full and wrap ----------------
        for (int i = 0; i < 8; i++) rx_push(8'hA0 + 8'(i));
        check("rx_full_ready", {31'h0, uart_rx_ready}, 32'h0);
        rx_push(8'hFF);
        bus_read(32'h8000_0004, d); check("rx_full_head", d, 32'hA0);
        check("rx_ready_after_pop", {31'h0, uart_rx_ready}, 32'h1);
        rx_push(8'hA8);
        for (int i = 0; i < 8; i++) begin
            bus_read(32'h8000_0004, d);
            check($sformatf("rx_order[%0d]", i), d, 32'hA1 + i);
        end
        bus_read(32'h8000_0004, d); check("rx_drained", d, 32'h0);

        // ---------------- counters ----------------
        bus_write(32'h8000_0018, 32'h0);
        for (int i = 0; i < 20; i++) begin
            inst_retire = (i % 4 == 1);
            step();
        end
        inst_retire = 1'b0;
        bus_read(32'h8000_0014, d); check("inst_cnt_5", d, 32'd5);
        bus_write(32'h8000_0018, 32'hDEAD_BEEF);
        bus_read(32'h8000_0010, d); check("cyc_after_rst", d, 32'd0);
        bus_read(32'h8000_0014, d); check("inst_after_rst", d, 32'd0);

        // Simultaneous retire and counter reset: reset wins.
        inst_retire = 1'b1;
        bus_write(32'h8000_0018, 32'h0);
        inst_retire = 1'b0;
        bus_read(32'h8000_0014, d); check("inst_rst_priority", d, 32'd0);

        // ---------------- cycle counter wrap ----------------
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt;
        addr = 32'h8000_0010; re = 1'b1;
        step(); check("cyc_max", rdata, 32'hFFFF_FFFF);
        step(); check("cyc_wrap", rdata, 32'h0);
        re = 1'b0;

        // ---------------- reset mid-TX ----------------
        rx_push(8'h5A);
        uart_tx_ready = 1'b1;
        bus_write(32'h8000_0008, 32'h0000_0042);
        uart_tx_ready = 1'b0;
        check("pre_reset_tx_valid", {31'h0, uart_tx_valid}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("async_tx_drop", {31'h0, uart_tx_valid}, 32'h0);
        check("async_rdata_zero", rdata, 32'h0);
        step(); step();
        rst = 1'b1;
        uart_tx_ready = 1'b1;
        step();
        bus_read(32'h8000_0000, d); check("status_post_reset", d, 32'h1);
        bus_read(32'h8000_0004, d); check("rx_empty_post_reset", d, 32'h0);

        // ---------------- randomized traffic vs model ----------------
        m_q.delete();
        m_tx_v = 1'b0;
        m_tx_d = 8'h00;
        m_cyc  = '0;
        m_inst = '0;
        for (int it = 0; it < 400; it++) begin
            int          kind;
            logic [31:0] a;
            logic        hit_m, pop_m, push_m, cnt_rst_m, tx_wr_m;
            logic [7:0]  off_m;
            logic [31:0] exp_rd;
            logic [7:0]  offs[8];
            offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C};

            kind = (it == 0) ? 100 : int'($urandom_range(0, 9));
            case ($urandom_range(0, 9))
                0:       a = 32'h8000_0100 | 32'($urandom_range(0, 255));
                1:       a = 32'($urandom_range(0, 255));
                default: a = 32'h8000_0000 | {24'h0, offs[$urandom_range(0, 7)]}
                             | 32'($urandom_range(0, 3));
            endcase
            if (kind == 100) a = 32'h8000_0018;

            re = 1'b0; we = '0;
            addr = a;
            wdata = $urandom();
            if (kind == 100 || (kind >= 5 && kind <= 7)) we = 4'($urandom_range(1, 15));
            else if (kind <= 4) re = 1'b1;
            inst_retire   = 1'($urandom_range(0, 1));
            uart_rx_valid = ($urandom_range(0, 2) != 0);
            uart_rx_data  = 8'($urandom());
            uart_tx_ready = 1'($urandom_range(0, 1));

            check("rnd_rx_ready", {31'h0, uart_rx_ready}, {31'h0, m_q.size() < 8});

            hit_m = (a[31:8] == 24'h80_0000);
            off_m = {a[7:2], 2'b00};
            exp_rd = 32'h0;
            if (re && hit_m) begin
                if (off_m == 8'h00)      exp_rd = {30'h0, m_q.size() > 0, !m_tx_v && uart_tx_ready};
                else if (off_m == 8'h04) exp_rd = (m_q.size() > 0) ? {24'h0, m_q[0]} : 32'h0;
                else if (off_m == 8'h10) exp_rd = m_cyc;
                else if (off_m == 8'h14) exp_rd = m_inst;
            end
            pop_m     = re && hit_m && off_m == 8'h04 && m_q.size() > 0;
            push_m    = uart_rx_valid && m_q.size() < 8;
            cnt_rst_m = (we != 0) && hit_m && off_m == 8'h18;
            tx_wr_m   = (we != 0) && hit_m && off_m == 8'h08;

            if (pop_m)  void'(m_q.pop_front());
            if (push_m) m_q.push_back(uart_rx_data);
            if (m_tx_v && uart_tx_ready) m_tx_v = 1'b0;
            else if (tx_wr_m && !m_tx_v && uart_tx_ready) begin
                m_tx_v = 1'b1;
                m_tx_d = wdata[7:0];
            end
            if (cnt_rst_m) begin
                m_cyc = 0; m_inst = 0;
            end else begin
                m_cyc  = m_cyc + 1;
                m_inst = m_inst + 32'(inst_retire);
            end

            step();
            check("rnd_rdata", rdata, exp_rd);
            check("rnd_tx_valid", {31'h0, uart_tx_valid}, {31'h0, m_tx_v});
            check("rnd_tx_data", {24'h0, uart_tx_data}, {24'h0, m_tx_d});
        end
        re = 1'b0; we = '0; uart_rx_valid = 1'b0; inst_retire = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
